if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the OpenMIPS pipeline. It owns the program counter and drives the chip-enable and address of the instruction ROM. It captures the combinational ROM data into the IF/ID pipeline register for the decode stage. It handles stall, branch redirect and flush (exception/eret) requests from the rest of the core.

## Interface
- `RESET_PC`, default 32'h00000000: fetch address after reset.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall_if`  in  1  hold PC (IF stage stalled).
- `stall_id`  in  1  hold IF/ID register (ID stage stalled).
- `flush`  in  1  pipeline flush (exception or eret).
- `new_pc`  in  32  flush target address.
- `branch_flag`  in  1  taken branch/jump resolved in ID this cycle.
- `branch_target_addr`  in  32  branch/jump target.
- `rom_ce`  out  1  ROM chip enable, registered.
- `rom_addr`  out  32  ROM byte address; equals `pc`.
- `rom_inst`  in  32  ROM data, combinational from `rom_addr`/`rom_ce`.
- `id_pc`  out  32  PC of the instruction in IF/ID.
- `id_inst`  out  32  instruction in IF/ID.
- `id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `id_adel`  out  1  IF/ID instruction was fetched from a misaligned PC.

## Operation
- Reset (`rst`=1 at an edge):
  - `rom_ce`=0, `pc`=`RESET_PC`.
  - `id_pc`=0, `id_inst`=0, `id_valid`=0, `id_adel`=0.
  - Reset overrides every other input.
- Start-up:
  - The first edge with `rst`=0 sets `rom_ce`=1 and leaves `pc` at `RESET_PC`.
  - `pc` never advances while `rom_ce`=0, so the first instruction fetched is at `RESET_PC`.
- PC update, with `rom_ce`=1, in priority order:
  1. `flush`: `pc`←`new_pc`.
  2. `stall_if`: `pc` held.
  3. `branch_flag`: `pc`←`branch_target_addr`.
  4. Otherwise: `pc`←`pc`+4. Wraps modulo 2^32, so 0xFFFFFFFC→0x00000000, with no flag.
- IF/ID update, in priority order:
  1. `flush`: load a bubble: `id_inst`=0, `id_pc`=0, `id_valid`=0, `id_adel`=0.
  2. `stall_if`=1 and `stall_id`=1: hold all IF/ID outputs.
  3. `stall_if`=1 and `stall_id`=0: load a bubble.
  4. `stall_if`=0:
     - Load `id_pc`←`pc`, `id_inst`←`rom_inst`, `id_valid`←`rom_ce`, `id_adel`←(`pc[1:0]`≠0).
     - When `id_adel` is loaded as 1, `id_inst` is forced to 0.
- Branch delay slot: `branch_flag` does not squash the instruction currently in IF. It is latched normally, because it is the delay slot.
- `flush` together with `branch_flag` or `stall_if`: `flush` wins for both PC and IF/ID.
- `rom_addr` is `pc` unmodified. The ROM uses word index `addr[N+1:2]`.
- The block performs no alignment correction itself; misalignment is only reported via `id_adel`.
- `rom_ce`, once set, stays 1 until the next reset.

## Timing
- `rom_addr`/`rom_ce` are register outputs, valid from the edge after which they were updated.
- `rom_inst` must settle within the same cycle; it is sampled at the next edge.
- Fetch latency: an instruction at address A appears on `id_inst`/`id_pc` at the edge ending the cycle in which `pc`=A. This is one cycle after `pc` became A.
- Branch penalty:
  - `branch_flag` asserted in cycle n puts the target on `rom_addr` in cycle n+1.
  - The target instruction reaches IF/ID at the end of cycle n+1.
  - The delay-slot instruction reaches IF/ID at the end of cycle n.
- Flush:
  - `flush` in cycle n gives a bubble in IF/ID in cycle n+1 and `pc`=`new_pc` in cycle n+1.
  - The handler's first instruction is in IF/ID at the end of cycle n+1.
- Reset mid-operation: the next edge returns the block to the full reset state regardless of stall, flush or branch.
- Zero combinational paths from inputs to outputs.

## Test plan
- Reset then run, ROM holding 0x34011100 at word 0 and 0x34020020 at word 1, no stalls:
  - `rom_ce` rises one cycle after reset release.
  - `id_inst` = 0x34011100 (`id_pc`=0), then 0x34020020 (`id_pc`=4).
  - `id_valid`=1 from the first fetch.
- Branch: `branch_flag`=1 with target 0x40 while `pc`=0x0C:
  - IF/ID receives the delay slot at 0x0C.
  - The next IF/ID entry has `id_pc`=0x40.
  - No bubble appears.
- Stall: `stall_if`=`stall_id`=1 for 3 cycles, then `stall_if`=1 and `stall_id`=0 for 1 cycle:
  - `pc` and IF/ID hold for 3 cycles.
  - Then one bubble (`id_valid`=0, `id_inst`=0), with `pc` unchanged.
- Flush with `new_pc`=0x20, asserted together with `branch_flag` (target 0x80) and `stall_if`=1:
  - Next cycle `pc`=0x20 and IF/ID holds a bubble.
  - The following entry has `id_pc`=0x20.
- Misalignment: `branch_target_addr`=0x42:
  - IF/ID gets `id_pc`=0x42, `id_adel`=1, `id_inst`=0.
  - The sequential PC then moves to 0x46.
- Wrap and reset: with `pc`=0xFFFFFFFC, the next fetch is at 0x00000000. Asserting `rst` for one cycle mid-stream forces all outputs to their reset values and `rom_ce`=0 on the next edge.

Source files
------------

// File: rtl/if_fetch_if.sv
// Bundles the fetch stage's control inputs, instruction-ROM port and IF/ID outputs.
// "master" is the fetch stage itself; "slave" is the surrounding core and ROM.
interface if_fetch_if;
    logic        stall_if;
    logic        stall_id;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target_addr;

    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;

    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_adel;

    modport master (
        input  stall_if,
        input  stall_id,
        input  flush,
        input  new_pc,
        input  branch_flag,
        input  branch_target_addr,
        output rom_ce,
        output rom_addr,
        input  rom_inst,
        output id_pc,
        output id_inst,
        output id_valid,
        output id_adel
    );

    modport slave (
        output stall_if,
        output stall_id,
        output flush,
        output new_pc,
        output branch_flag,
        output branch_target_addr,
        input  rom_ce,
        input  rom_addr,
        output rom_inst,
        input  id_pc,
        input  id_inst,
        input  id_valid,
        input  id_adel
    );
endinterface

// File: rtl/if_fetch.sv
// OpenMIPS instruction-fetch stage: owns the PC, drives the instruction ROM and
// fills the IF/ID pipeline register, honouring flush, stall and branch redirects.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      rst,
    if_fetch_if.master bus
);

    logic        rom_ce_q, rom_ce_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic        fetch_misaligned;

    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        id_adel_q, id_adel_d;

    // The PC stays parked at RESET_PC until the ROM is enabled, so the first fetch is RESET_PC.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        rom_ce_d = 1'b1;
        pc_d     = pc_q;
        if (rom_ce_q) begin
            if (bus.flush) begin
                pc_d = bus.new_pc;
            end else if (!bus.stall_if) begin
                if (bus.branch_flag) begin
                    pc_d = bus.branch_target_addr;
                end else begin
                    pc_d = pc_plus4;
                end
            end
        end
    end

    // A branch never squashes the instruction in IF: that instruction is the delay slot.
    always_comb begin
        fetch_misaligned = (pc_q[1:0] != 2'b00);
        id_pc_d          = id_pc_q;
        id_inst_d        = id_inst_q;
        id_valid_d       = id_valid_q;
        id_adel_d        = id_adel_q;
        if (bus.flush || (bus.stall_if && !bus.stall_id)) begin
            id_pc_d    = 32'h0;
            id_inst_d  = 32'h0;
            id_valid_d = 1'b0;
            id_adel_d  = 1'b0;
        end else if (!bus.stall_if) begin
            id_pc_d    = pc_q;
            id_inst_d  = fetch_misaligned ? 32'h0 : bus.rom_inst;
            id_valid_d = rom_ce_q;
            id_adel_d  = fetch_misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_ce_q   <= 1'b0;
            pc_q       <= RESET_PC;
            id_pc_q    <= 32'h0;
            id_inst_q  <= 32'h0;
            id_valid_q <= 1'b0;
            id_adel_q  <= 1'b0;
        end else begin
            rom_ce_q   <= rom_ce_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            id_adel_q  <= id_adel_d;
        end
    end

    assign bus.rom_ce   = rom_ce_q;
    assign bus.rom_addr = pc_q;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_inst  = id_inst_q;
    assign bus.id_valid = id_valid_q;
    assign bus.id_adel  = id_adel_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed, table-driven bench for if_fetch with a small combinational ROM model.
module tb_if_fetch;

    typedef struct {
        logic        rst;
        logic        stall_if;
        logic        stall_id;
        logic        flush;
        logic [31:0] new_pc;
        logic        branch_flag;
        logic [31:0] bta;
        logic        exp_ce;
        logic [31:0] exp_addr;
        logic [31:0] exp_id_pc;
        logic [31:0] exp_id_inst;
        logic        exp_valid;
        logic        exp_adel;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] rom_mem [64];
    vec_t        vecs [$];
    int          num_checks;
    int          num_fails;

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rom_inst = bus.rom_ce ? rom_mem[bus.rom_addr[7:2]] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(
        input logic rst_i, input logic sif, input logic sid, input logic fl,
        input logic [31:0] npc, input logic bf, input logic [31:0] bta,
        input logic ce, input logic [31:0] addr, input logic [31:0] ipc,
        input logic [31:0] iinst, input logic vld, input logic adel);
        vec_t v;
        v.rst = rst_i; v.stall_if = sif; v.stall_id = sid; v.flush = fl;
        v.new_pc = npc; v.branch_flag = bf; v.bta = bta;
        v.exp_ce = ce; v.exp_addr = addr; v.exp_id_pc = ipc;
        v.exp_id_inst = iinst; v.exp_valid = vld; v.exp_adel = adel;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s step %0d: got %h, expected %h", name, idx, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        rst                    = v.rst;
        bus.stall_if           = v.stall_if;
        bus.stall_id           = v.stall_id;
        bus.flush              = v.flush;
        bus.new_pc             = v.new_pc;
        bus.branch_flag        = v.branch_flag;
        bus.branch_target_addr = v.bta;
        @(posedge clk);
        #1;
        checkOutput("rom_ce",   idx, {31'h0, bus.rom_ce},   {31'h0, v.exp_ce});
        checkOutput("rom_addr", idx, bus.rom_addr,          v.exp_addr);
        checkOutput("id_pc",    idx, bus.id_pc,             v.exp_id_pc);
        checkOutput("id_inst",  idx, bus.id_inst,           v.exp_id_inst);
        checkOutput("id_valid", idx, {31'h0, bus.id_valid}, {31'h0, v.exp_valid});
        checkOutput("id_adel",  idx, {31'h0, bus.id_adel},  {31'h0, v.exp_adel});
    endtask

    initial begin
        num_checks = 0;
        num_fails  = 0;
        for (int i = 0; i < 64; i++) rom_mem[i] = 32'hA000_0000 + i;
        rom_mem[0] = 32'h3401_1100;
        rom_mem[1] = 32'h3402_0020;

        rst                    = 1'b1;
        bus.stall_if           = 1'b0;
        bus.stall_id           = 1'b0;
        bus.flush              = 1'b0;
        bus.new_pc             = 32'h0;
        bus.branch_flag        = 1'b0;
        bus.branch_target_addr = 32'h0;

        //                 rst sif sid fl  new_pc        bf  bta           ce addr          id_pc         id_inst       vld adel
        vecs.push_back(mkVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h0,        32'h3401_1100, 1, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h4,        32'h3402_0020, 1, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        32'h8,        32'hA000_0002, 1, 0));
        // branch at pc=0x0C: delay slot latched, then target
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        1, 32'h40,       1, 32'h40,       32'hC,        32'hA000_0003, 1, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h44,       32'h40,       32'hA000_0010, 1, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h48,       32'h44,       32'hA000_0011, 1, 0));
        // full stall for three cycles, then a single bubble
        vecs.push_back(mkVec(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h48,       32'h44,       32'hA000_0011, 1, 0));
        vecs.push_back(mkVec(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h48,       32'h44,       32'hA000_0011, 1, 0));
        vecs.push_back(mkVec(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h48,       32'h44,       32'hA000_0011, 1, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h48,       32'h0,        32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4C,       32'h48,       32'hA000_0012, 1, 0));
        // flush beats branch and stall
        vecs.push_back(mkVec(0, 1, 0, 1, 32'h20,       1, 32'h80,       1, 32'h20,       32'h0,        32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h24,       32'h20,       32'hA000_0008, 1, 0));
        // misaligned branch target
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        1, 32'h42,       1, 32'h42,       32'h24,       32'hA000_0009, 1, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h46,       32'h42,       32'h0,        1, 1));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4A,       32'h46,       32'h0,        1, 1));

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // wrap-around of the sequential PC at the top of the address space
        applyStimulus(mkVec(0, 0, 0, 1, 32'hFFFF_FFF8, 0, 32'h0, 1, 32'hFFFF_FFF8, 32'h0,        32'h0,         0, 0), 100);
        applyStimulus(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hA000_003E, 1, 0), 101);
        applyStimulus(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0, 1, 32'h0,        32'hFFFF_FFFC, 32'hA000_003F, 1, 0), 102);
        applyStimulus(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0, 1, 32'h4,        32'h0,        32'h3401_1100, 1, 0), 103);

        // reset mid-stream overrides flush, branch and stall, then restarts cleanly
        applyStimulus(mkVec(1, 1, 0, 1, 32'h20,       1, 32'h80, 0, 32'h0,        32'h0,        32'h0,         0, 0), 200);
        applyStimulus(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0, 1, 32'h0,        32'h0,        32'h0,         0, 0), 201);
        applyStimulus(mkVec(0, 0, 0, 0, 32'h0,        0, 32'h0, 1, 32'h4,        32'h0,        32'h3401_1100, 1, 0), 202);

        // flush while the ROM is still disabled must not move the PC
        applyStimulus(mkVec(1, 0, 0, 0, 32'h0,        0, 32'h0, 0, 32'h0,        32'h0,        32'h0,         0, 0), 300);
        applyStimulus(mkVec(0, 0, 0, 1, 32'h60,       0, 32'h0, 1, 32'h0,        32'h0,        32'h0,         0, 0), 301);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
